// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   ST_IDLE/ST_RUN/ST_FIX : 2-bit FSM state encoding
//   STEP_W                : step counter width for the default 8-bit operand
//   step_w()              : step counter width for any even WIDTH >= 4
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int DEF_WIDTH = 8;
    localparam int STEP_W    = $clog2(DEF_WIDTH / 2);

    // Counter must reach WIDTH/2-1; WIDTH>=4 keeps this at least 1 bit.
    function automatic int step_w(input int width);
        return $clog2(width / 2);
    endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational radix-4 digit multiplier.
//   a     in  WIDTH    unsigned multiplicand magnitude
//   digit in  2        multiplier digit 0..3
//   pp    out WIDTH+2  a * digit
module mult_digit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       digit,
    output logic [WIDTH+1:0] pp
);

    always_comb begin
        pp = '0;
        case (digit)
            2'd0: pp = '0;
            2'd1: pp = {2'b00, a};
            2'd2: pp = {1'b0, a, 1'b0};
            2'd3: pp = {2'b00, a} + {1'b0, a, 1'b0};
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, two multiplier bits per clock.
// Operates on magnitudes and applies the sign once at the end.
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request a multiply (sampled only while idle)
//   signed_mode in   1 = two's complement operands (sampled with start)
//   a, b        in   WIDTH-bit multiplicand / multiplier (sampled with start)
//   busy        out  operation in progress
//   done        out  one-cycle pulse, new product valid
//   product     out  2*WIDTH-bit result, held until the next completion
module seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SW = step_w(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH / 2 - 1);

    logic [1:0]       state, state_nxt;
    logic             load, run, fix;
    logic [WIDTH-1:0] a_mag, b_sh;
    logic             sign;
    logic [PW-1:0]    acc;
    logic [SW-1:0]    step;
    logic [WIDTH+1:0] pp;
    logic             a_neg, b_neg;

    mult_digit #(.WIDTH(WIDTH)) u_digit (
        .a     (a_mag),
        .digit (b_sh[1:0]),
        .pp    (pp)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (step == STEP_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        load = 1'b0;
        run  = 1'b0;
        fix  = 1'b0;
        case (state)
            ST_IDLE: load = start;
            ST_RUN:  run  = 1'b1;
            ST_FIX:  fix  = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = signed_mode & a[WIDTH-1];
    assign b_neg = signed_mode & b[WIDTH-1];

    // Datapath. Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1),
    // which is the correct unsigned magnitude, so no extra bit is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag   <= '0;
            b_sh    <= '0;
            sign    <= 1'b0;
            acc     <= '0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_mag <= a_neg ? (~a) + WIDTH'(1) : a;
                b_sh  <= b_neg ? (~b) + WIDTH'(1) : b;
                sign  <= a_neg ^ b_neg;
                acc   <= '0;
                step  <= '0;
                busy  <= 1'b1;
            end
            if (run) begin
                // Digit weight is 4^step; zero-extended partial product
                // shifted by at most WIDTH-2 still fits in 2*WIDTH bits.
                acc  <= acc + (PW'(pp) << {step, 1'b0});
                b_sh <= b_sh >> 2;
                step <= step + SW'(1);
            end
            if (fix) begin
                product <= sign ? (~acc) + PW'(1) : acc;
                done    <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;

    localparam int W   = 8;
    localparam int LAT = W / 2 + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;

    seq_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit           sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [15:0]  exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands as interpreted by mode.
    function automatic logic [15:0] ref_mul(input bit sm, input logic [W-1:0] x, input logic [W-1:0] y);
        longint xv, yv, p;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        p  = xv * yv;
        return p[15:0];
    endfunction

    // One full operation: returns product, edges from E0 to done, busy
    // cycles seen, busy value in the done cycle.
    task automatic run_op(input bit sm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output logic [15:0] p, output int lat, output int bcnt,
                          output logic busy_at_done);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!done && busy) bcnt++;
        end
        p = product;
        busy_at_done = busy;
    endtask

    logic [15:0] p, exp_p;
    int          lat, bcnt, cnt, cyc;
    logic        bd;
    bit          sm;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corners [4];
    int          dcyc [3];
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];
    int          k;

    initial begin
        tbl[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
        tbl[1] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        tbl[2] = '{1'b0, 8'd0,   8'd200, 16'h0000};
        tbl[3] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
        tbl[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        tbl[5] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
        tbl[6] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        tbl[7] = '{1'b0, 8'h80,  8'h02,  16'h0100};
        corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].sm, tbl[i].a, tbl[i].b, p, lat, bcnt, bd);
            chk($sformatf("tbl%0d_product", i), p, tbl[i].exp);
            chk($sformatf("tbl%0d_latency", i), lat, LAT);
            chk($sformatf("tbl%0d_busy_cycles", i), bcnt, LAT);
            chk($sformatf("tbl%0d_busy_at_done", i), bd, 0);
        end

        // Done is a single-cycle pulse
        @(negedge clk);
        chk("done_pulse_width", done, 0);

        // Second start at E2 must be ignored
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 8'd13; b = 8'd11;
        @(posedge clk);            // E0
        @(negedge clk); start = 1'b0;
        @(posedge clk);            // E1
        @(negedge clk); start = 1'b1; a = 8'd200; b = 8'd3;
        @(posedge clk);            // E2
        @(negedge clk); start = 1'b0;
        lat = 2;
        while (!done && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk("ignored_start_latency", lat, LAT);
        chk("ignored_start_product", product, 16'h008F);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("ignored_start_no_second_done", cnt, 0);

        // start held high: a new operation is taken on the edge after done
        qa[0] = 8'd13;  qb[0] = 8'd11;
        qa[1] = 8'hFF;  qb[1] = 8'h02;
        qa[2] = 8'd100; qb[2] = 8'd7;
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = qa[0]; b = qb[0];
        k = 0; cyc = 0;
        while (k < 3 && cyc < 60) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (done) begin
                dcyc[k] = cyc;
                chk($sformatf("b2b_product%0d", k), product, ref_mul(1'b0, qa[k], qb[k]));
                k++;
                if (k < 3) begin a = qa[k]; b = qb[k]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", k, 3);
        if (k == 3) begin
            chk("b2b_first_latency", dcyc[0], LAT + 1);
            chk("b2b_spacing01", dcyc[1] - dcyc[0], LAT + 1);
            chk("b2b_spacing12", dcyc[2] - dcyc[1], LAT + 1);
        end

        // Reset during RUN aborts immediately
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; a = 8'hFF; b = 8'h7F;
        @(posedge clk);            // E0
        @(negedge clk); start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk);   // E1..E3
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        run_op(1'b0, 8'd7, 8'd9, p, lat, bcnt, bd);
        chk("after_abort_product", p, 16'd63);
        chk("after_abort_latency", lat, LAT);

        // All corner operand pairs in both modes
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    run_op(m[0], corners[i], corners[j], p, lat, bcnt, bd);
                    chk($sformatf("corner_m%0d_%0h_%0h", m, corners[i], corners[j]), p,
                        ref_mul(m[0], corners[i], corners[j]));
                end

        // Random operands, both modes, biased toward corners
        for (int n = 0; n < 10000; n++) begin
            sm = bit'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            exp_p = ref_mul(sm, ra, rb);
            run_op(sm, ra, rb, p, lat, bcnt, bd);
            chk($sformatf("rand%0d_m%0d_%0h_%0h", n, sm, ra, rb), p, exp_p);
            if (lat != LAT) chk($sformatf("rand%0d_latency", n), lat, LAT);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
